pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline; its main addition is a load-use stall, which the baseline 5-stage datapath does not provide.
- Keeps a scoreboard of in-flight destination registers for the NSTAGE stages after decode.
- Generates IF/ID hold, ID/EX bubble insertion, per-operand forwarding selects, a WB→ID bypass, control-hazard flushes with a kill mask, and saturating stall/flush event counters.

Parameters:
- ADDR_WIDTH, 5: register index width.
- NSTAGE, 3: number of post-decode stages tracked (stage 0 = EX, 1 = MEM, 2 = WB); minimum 2.
- BR_STAGE, 0: stage index whose redirect request resolves branches and jumps; must be < NSTAGE.
- SELW, $clog2(NSTAGE+1): width of the forward-select codes.
- CNT_WIDTH, 16: width of the event counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- ext_stall  in  1  freezes the whole pipeline, e.g. for a multi-cycle memory access.
- id_valid  in  1  a valid instruction is in ID.
- id_rs1, id_rs2  in  ADDR_WIDTH  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads that operand.
- id_rd  in  ADDR_WIDTH  destination register of the ID instruction.
- id_regwrite  in  1  the ID instruction writes a register.
- id_is_load  in  1  the ID instruction is a load.
- redirect_req  in  1  the instruction in stage BR_STAGE was taken or is a jump.
- redirect_target  in  32  new PC for the redirect.
- stall_if  out  1  hold the PC and the IF/ID register.
- bubble_idex  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  clear IF/ID.
- kill_mask  out  NSTAGE  bit k clears the control signals of stage k.
- pc_redirect_valid  out  1  take pc_redirect.
- pc_redirect  out  32  target PC.
- fwd_sel_a, fwd_sel_b  out  SELW  registered; valid while the consumer is in EX. Code 0 = ID/EX operand; code k = result from the output of pipeline register k.
- wb_bypass_a, wb_bypass_b  out  1  combinational; ID must take WriteData_WB for that operand.
- stall_cnt, flush_cnt  out  CNT_WIDTH  event counters.

Behaviour:
- Reset (rst low, asynchronous): all scoreboard entries invalid; fwd_sel_a and fwd_sel_b = 0; both counters = 0.
- Combinational outputs during reset: stall_if = bubble_idex = flush_ifid = 0, kill_mask = 0, pc_redirect_valid = 0.
- Scoreboard entry k holds {valid, rd, ready_stage}.
  - ready_stage = 1 for ALU results and 2 for loads.
  - Meaning: the result is available from the output of pipeline register ready_stage.
- Scoreboard shift: when no freeze is active, entry k+1 takes entry k, entry NSTAGE-1 retires, and entry 0 is loaded from ID.
- Entry 0 load rule: entry 0 is valid only if id_valid & id_regwrite & (id_rd != 0) & !stall & !redirect.
- Operand match: rs matches entry k if the operand is used, entry k is valid, rs != 0 and rs == entry k rd. The youngest match (lowest k) wins.
- Hazard check for a match at k < NSTAGE-1:
  - Next cycle the producer sits in stage k+1.
  - If k+1 < ready_stage, a load-use hazard exists and stall = 1.
  - Otherwise the operand's fwd_sel is registered as k+1.
- A match at k = NSTAGE-1 asserts the wb_bypass output for that operand; fwd_sel = 0.
- stall = id_valid & hazard & !redirect_req.
  - Effect: stall_if = 1, bubble_idex = 1, entry 0 loads invalid, and the fwd_sel registers load 0.
  - Example: load immediately followed by a dependent instruction gives exactly 1 stall cycle at NSTAGE = 3.
- Redirect (redirect_req & !ext_stall), which has priority over stall:
  - pc_redirect_valid = 1 and pc_redirect = redirect_target.
  - flush_ifid = 1 and bubble_idex = 1.
  - kill_mask bits [BR_STAGE-1:0] = 1, and those scoreboard entries are invalidated in the same shift.
  - stall_if = 0.
- ext_stall = 1:
  - Scoreboard, fwd_sel registers and counters hold.
  - stall_if = 1; every other combinational output is 0.
  - A redirect_req raised during ext_stall is ignored; its source must hold it until ext_stall drops.
- Counters: stall_cnt increments on each stall cycle; flush_cnt increments on each redirect cycle. Both saturate at all-ones and do not wrap.
- Reset asserted mid-stall or mid-redirect: all state clears immediately; no pending action survives reset.

Test Plan:
- Reset: rst = 0 with random inputs → all outputs 0. Release rst, then id_valid with no producers in flight → stall_if = 0 and fwd_sel = 0 for 5 cycles.
- ALU forward: "add x5" in ID, then "sub x6, x5, x1" next cycle → fwd_sel_a = 1 while sub is in EX. Insert one unrelated instruction between them → fwd_sel_a = 2. Insert two → wb_bypass_a = 1 in ID.
- Load-use: "lw x7", then "add x8, x7, x7" → exactly one cycle with stall_if = 1 and bubble_idex = 1, then fwd_sel_a = fwd_sel_b = 2, stall_cnt = 1.
- x0 and youngest-wins: producers of x3 at stages 0 and 1 → fwd_sel = 1 (the stage-0 producer). A producer writing x0 → never matches; fwd_sel = 0, no stall.
- Redirect vs stall: redirect_req in the same cycle as a load-use hazard → stall_if = 0, flush_ifid = 1, pc_redirect = redirect_target (e.g. 0x0000_0040), flush_cnt = 1, stall_cnt unchanged. With BR_STAGE = 1 → kill_mask = 3'b001.
- ext_stall and saturation:
  - Hold ext_stall 4 cycles during a hazard → scoreboard is frozen, and the stall resumes exactly once after ext_stall drops.
  - With CNT_WIDTH = 2, 5 stalls → stall_cnt = 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and forwarding controller for an in-order RISC-V pipeline. It keeps
// a small scoreboard of the destination registers in flight in the NSTAGE
// stages after decode (0 = EX, 1 = MEM, 2 = WB). It uses that scoreboard to
// generate:
//   - load-use stalls,
//   - per-operand forwarding selects,
//   - a WB->ID bypass,
//   - control-hazard flushes,
//   - saturating stall/flush event counters.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   ext_stall             freeze the whole pipeline (e.g. slow memory)
//   id_*                  decoded fields of the instruction sitting in ID
//   redirect_req/_target  taken branch / jump resolved in stage BR_STAGE
//   stall_if              hold PC and IF/ID
//   bubble_idex           load a NOP into ID/EX
//   flush_ifid            clear IF/ID
//   kill_mask             bit k clears the control signals of stage k
//   pc_redirect_valid/pc_redirect  PC redirect request
//   fwd_sel_a/b           registered forward selects, valid while consumer is in EX
//                         (0 = ID/EX operand, k = output of pipeline register k)
//   wb_bypass_a/b         ID must take WriteData_WB for that operand
//   stall_cnt, flush_cnt  saturating event counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int NSTAGE     = 3,
  parameter int BR_STAGE   = 0,
  parameter int SELW       = $clog2(NSTAGE + 1),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_stall,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  redirect_req,
  input  logic [31:0]           redirect_target,
  output logic                  stall_if,
  output logic                  bubble_idex,
  output logic                  flush_ifid,
  output logic [NSTAGE-1:0]     kill_mask,
  output logic                  pc_redirect_valid,
  output logic [31:0]           pc_redirect,
  output logic [SELW-1:0]       fwd_sel_a,
  output logic [SELW-1:0]       fwd_sel_b,
  output logic                  wb_bypass_a,
  output logic                  wb_bypass_b,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  flush_cnt
);

  // Pipeline register whose output first carries the result.
  localparam logic [SELW-1:0] RDY_ALU  = SELW'(1);
  localparam logic [SELW-1:0] RDY_LOAD = SELW'(2);

  // Entries younger than the branch stage belong to the wrong path.
  localparam logic [NSTAGE-1:0] KILL_BITS = NSTAGE'((64'd1 << BR_STAGE) - 64'd1);

  // Scoreboard: entry k describes the producer currently in stage k.
  logic [NSTAGE-1:0]                 sb_valid_r, sb_valid_n;
  logic [NSTAGE-1:0][ADDR_WIDTH-1:0] sb_rd_r, sb_rd_n;
  logic [NSTAGE-1:0][SELW-1:0]       sb_rdy_r, sb_rdy_n;

  logic [SELW-1:0]      fwd_a_r, fwd_b_r, fwd_a_n, fwd_b_n;
  logic [CNT_WIDTH-1:0] stall_cnt_r, flush_cnt_r, stall_cnt_n, flush_cnt_n;

  logic            haz_a_s, haz_b_s, byp_a_s, byp_b_s;
  logic [SELW-1:0] fwd_a_s, fwd_b_s;
  logic            stall_s, redirect_s;

  // Classify one operand against the scoreboard; returns {hazard, wb_bypass, fwd_sel}.
  // Scanning from the oldest entry down lets the youngest match overwrite older ones.
  function automatic logic [SELW+1:0] eval_operand(
    input logic                             use_op,
    input logic [ADDR_WIDTH-1:0]            rs,
    input logic [NSTAGE-1:0]                vld,
    input logic [NSTAGE-1:0][ADDR_WIDTH-1:0] rd,
    input logic [NSTAGE-1:0][SELW-1:0]      rdy
  );
    logic            hit;
    int              idx;
    logic [SELW-1:0] hit_rdy;
    hit     = 1'b0;
    idx     = 0;
    hit_rdy = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (use_op && vld[k] && (rs != '0) && (rs == rd[k])) begin
        hit     = 1'b1;
        idx     = k;
        hit_rdy = rdy[k];
      end else begin
        hit = hit;
      end
    end
    if (!hit) begin
      eval_operand = '0;
    end else if (idx == NSTAGE - 1) begin
      // Producer is writing back this cycle: the register file read is stale.
      eval_operand = {1'b0, 1'b1, {SELW{1'b0}}};
    end else if ((idx + 1) < int'(hit_rdy)) begin
      // Result not yet out of its pipeline register when the consumer hits EX.
      eval_operand = {1'b1, 1'b0, {SELW{1'b0}}};
    end else begin
      eval_operand = {1'b0, 1'b0, SELW'(idx + 1)};
    end
  endfunction

  // Operand dependency classification for both source registers.
  always_comb begin
    {haz_a_s, byp_a_s, fwd_a_s} = eval_operand(id_use_rs1, id_rs1, sb_valid_r, sb_rd_r, sb_rdy_r);
    {haz_b_s, byp_b_s, fwd_b_s} = eval_operand(id_use_rs2, id_rs2, sb_valid_r, sb_rd_r, sb_rdy_r);
  end

  // A redirect overrides a stall, and ext_stall suppresses both.
  assign redirect_s = redirect_req & ~ext_stall;
  assign stall_s    = id_valid & (haz_a_s | haz_b_s) & ~redirect_req & ~ext_stall;

  // Scoreboard shift with wrong-path invalidation and entry-0 load from ID.
  always_comb begin
    sb_valid_n = sb_valid_r;
    sb_rd_n    = sb_rd_r;
    sb_rdy_n   = sb_rdy_r;
    if (!ext_stall) begin
      for (int k = NSTAGE - 1; k >= 1; k--) begin
        sb_valid_n[k] = sb_valid_r[k-1] & ~(redirect_s & KILL_BITS[k-1]);
        sb_rd_n[k]    = sb_rd_r[k-1];
        sb_rdy_n[k]   = sb_rdy_r[k-1];
      end
      sb_valid_n[0] = id_valid & id_regwrite & (id_rd != '0) & ~stall_s & ~redirect_s;
      sb_rd_n[0]    = id_rd;
      sb_rdy_n[0]   = id_is_load ? RDY_LOAD : RDY_ALU;
    end else begin
      sb_valid_n = sb_valid_r;
    end
  end

  // Forward-select and saturating counter next values.
  always_comb begin
    fwd_a_n     = fwd_a_r;
    fwd_b_n     = fwd_b_r;
    stall_cnt_n = stall_cnt_r;
    flush_cnt_n = flush_cnt_r;
    if (ext_stall) begin
      fwd_a_n = fwd_a_r;
      fwd_b_n = fwd_b_r;
    end else if (stall_s) begin
      // The bubble entering EX must not pick up a forwarded value.
      fwd_a_n = '0;
      fwd_b_n = '0;
    end else begin
      fwd_a_n = fwd_a_s;
      fwd_b_n = fwd_b_s;
    end
    if (stall_s && (stall_cnt_r != '1)) begin
      stall_cnt_n = stall_cnt_r + CNT_WIDTH'(1);
    end else begin
      stall_cnt_n = stall_cnt_r;
    end
    if (redirect_s && (flush_cnt_r != '1)) begin
      flush_cnt_n = flush_cnt_r + CNT_WIDTH'(1);
    end else begin
      flush_cnt_n = flush_cnt_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid_r  <= '0;
      sb_rd_r     <= '0;
      sb_rdy_r    <= '0;
      fwd_a_r     <= '0;
      fwd_b_r     <= '0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      sb_valid_r  <= sb_valid_n;
      sb_rd_r     <= sb_rd_n;
      sb_rdy_r    <= sb_rdy_n;
      fwd_a_r     <= fwd_a_n;
      fwd_b_r     <= fwd_b_n;
      stall_cnt_r <= stall_cnt_n;
      flush_cnt_r <= flush_cnt_n;
    end
  end

  // Combinational control outputs, forced quiet while reset is asserted.
  always_comb begin
    stall_if          = 1'b0;
    bubble_idex       = 1'b0;
    flush_ifid        = 1'b0;
    kill_mask         = '0;
    pc_redirect_valid = 1'b0;
    pc_redirect       = 32'h0000_0000;
    wb_bypass_a       = 1'b0;
    wb_bypass_b       = 1'b0;
    if (rst) begin
      stall_if          = ext_stall | stall_s;
      bubble_idex       = stall_s | redirect_s;
      flush_ifid        = redirect_s;
      pc_redirect_valid = redirect_s;
      wb_bypass_a       = byp_a_s & ~ext_stall;
      wb_bypass_b       = byp_b_s & ~ext_stall;
      if (redirect_s) begin
        kill_mask   = KILL_BITS;
        pc_redirect = redirect_target;
      end else begin
        kill_mask   = '0;
        pc_redirect = 32'h0000_0000;
      end
    end else begin
      stall_if = 1'b0;
    end
  end

  assign fwd_sel_a = fwd_a_r;
  assign fwd_sel_b = fwd_b_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int NS = 3;

  logic        clk;
  logic        rst, ext_stall, id_valid, id_use_rs1, id_use_rs2;
  logic        id_regwrite, id_is_load, redirect_req;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] redirect_target;

  // Outputs of instance 0 (defaults) and instance 1 (BR_STAGE=1, CNT_WIDTH=2)
  logic        o_stall_if[2], o_bubble[2], o_flush[2], o_prv[2], o_byp_a[2], o_byp_b[2];
  logic [2:0]  o_kill[2];
  logic [31:0] o_pc[2];
  logic [1:0]  o_fa[2], o_fb[2];
  logic [15:0] sc0, fc0;
  logic [1:0]  sc1, fc1;

  int checks, errors;

  pipeline_hazard_ctrl u_dut0 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .redirect_req(redirect_req), .redirect_target(redirect_target),
    .stall_if(o_stall_if[0]), .bubble_idex(o_bubble[0]), .flush_ifid(o_flush[0]),
    .kill_mask(o_kill[0]), .pc_redirect_valid(o_prv[0]), .pc_redirect(o_pc[0]),
    .fwd_sel_a(o_fa[0]), .fwd_sel_b(o_fb[0]), .wb_bypass_a(o_byp_a[0]), .wb_bypass_b(o_byp_b[0]),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  pipeline_hazard_ctrl #(.BR_STAGE(1), .CNT_WIDTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .ext_stall(ext_stall), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .redirect_req(redirect_req), .redirect_target(redirect_target),
    .stall_if(o_stall_if[1]), .bubble_idex(o_bubble[1]), .flush_ifid(o_flush[1]),
    .kill_mask(o_kill[1]), .pc_redirect_valid(o_prv[1]), .pc_redirect(o_pc[1]),
    .fwd_sel_a(o_fa[1]), .fwd_sel_b(o_fb[1]), .wb_bypass_a(o_byp_a[1]), .wb_bypass_b(o_byp_b[1]),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of in-flight producers with their age in cycles since
  // leaving ID (age 0 = EX). Each instance has its own liveness bit per producer.
  typedef struct {
    logic [4:0] rd;
    bit         load;
    int         age;
    bit [1:0]   alive;
  } prod_t;

  prod_t flight[$];
  int    br[2]   = '{0, 1};
  int    cmax[2] = '{65535, 3};
  int    m_fa[2], m_fb[2], m_sc[2], m_fc[2];
  bit    e_stall[2];
  int    e_nfa[2], e_nfb[2];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    flight.delete();
    for (int i = 0; i < 2; i++) begin
      m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  // Youngest live producer of rs decides: bypass in WB, stall if not ready, else forward.
  task automatic eval_op(input int i, input bit use_op, input logic [4:0] rs,
                         output bit haz, output bit byp, output int fwd);
    int best;
    bit ld;
    best = -1; ld = 1'b0;
    haz = 1'b0; byp = 1'b0; fwd = 0;
    if (use_op && rs != 5'd0) begin
      foreach (flight[j]) begin
        if (flight[j].alive[i] && flight[j].rd == rs && (best < 0 || flight[j].age < best)) begin
          best = flight[j].age;
          ld   = flight[j].load;
        end
      end
    end
    if (best == NS - 1) byp = 1'b1;
    else if (best >= 0) begin
      if (best + 1 < (ld ? 2 : 1)) haz = 1'b1;
      else fwd = best + 1;
    end
  endtask

  task automatic check_all();
    bit ha, hb, ba, bb, st, rdr;
    int fa, fb;
    if (!rst) model_clear();
    for (int i = 0; i < 2; i++) begin
      eval_op(i, id_use_rs1, id_rs1, ha, ba, fa);
      eval_op(i, id_use_rs2, id_rs2, hb, bb, fb);
      st  = rst && id_valid && (ha || hb) && !redirect_req && !ext_stall;
      rdr = rst && redirect_req && !ext_stall;
      e_stall[i] = st; e_nfa[i] = fa; e_nfb[i] = fb;
      check_value($sformatf("stall_if[%0d]", i), 32'(o_stall_if[i]), 32'(rst && (ext_stall || st)));
      check_value($sformatf("bubble[%0d]", i), 32'(o_bubble[i]), 32'(st || rdr));
      check_value($sformatf("flush[%0d]", i), 32'(o_flush[i]), 32'(rdr));
      check_value($sformatf("pc_valid[%0d]", i), 32'(o_prv[i]), 32'(rdr));
      check_value($sformatf("kill[%0d]", i), 32'(o_kill[i]), rdr ? 32'((1 << br[i]) - 1) : 32'h0);
      check_value($sformatf("pc[%0d]", i), o_pc[i], rdr ? redirect_target : 32'h0);
      check_value($sformatf("byp_a[%0d]", i), 32'(o_byp_a[i]), 32'(rst && !ext_stall && ba));
      check_value($sformatf("byp_b[%0d]", i), 32'(o_byp_b[i]), 32'(rst && !ext_stall && bb));
      check_value($sformatf("fwd_a[%0d]", i), 32'(o_fa[i]), 32'(m_fa[i]));
      check_value($sformatf("fwd_b[%0d]", i), 32'(o_fb[i]), 32'(m_fb[i]));
      check_value($sformatf("stall_cnt[%0d]", i), (i == 0) ? 32'(sc0) : 32'(sc1), 32'(m_sc[i]));
      check_value($sformatf("flush_cnt[%0d]", i), (i == 0) ? 32'(fc0) : 32'(fc1), 32'(m_fc[i]));
    end
  endtask

  task automatic model_update();
    prod_t nq[$];
    prod_t p;
    if (!rst) begin
      model_clear();
      return;
    end
    if (ext_stall) return;
    for (int i = 0; i < 2; i++) begin
      m_fa[i] = e_stall[i] ? 0 : e_nfa[i];
      m_fb[i] = e_stall[i] ? 0 : e_nfb[i];
      if (e_stall[i] && m_sc[i] < cmax[i]) m_sc[i]++;
      if (redirect_req && m_fc[i] < cmax[i]) m_fc[i]++;
    end
    foreach (flight[j]) begin
      p = flight[j];
      for (int i = 0; i < 2; i++)
        if (redirect_req && p.age < br[i]) p.alive[i] = 1'b0;
      p.age = p.age + 1;
      if (p.age < NS) nq.push_back(p);
    end
    p.rd = id_rd; p.load = id_is_load; p.age = 0;
    for (int i = 0; i < 2; i++)
      p.alive[i] = id_valid && id_regwrite && (id_rd != 5'd0) && !e_stall[i] && !redirect_req;
    nq.push_back(p);
    flight = nq;
  endtask

  task automatic step();
    #2;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic issue(input bit v, input bit rw, input bit ld, input int rd,
                       input int rs1, input bit u1, input int rs2, input bit u2);
    id_valid = v; id_regwrite = rw; id_is_load = ld; id_rd = 5'(rd);
    id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
    ext_stall = 1'b0; redirect_req = 1'b0; redirect_target = 32'h0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3; c++) begin
      issue(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      step();
    end
  endtask

  task automatic rand_inputs();
    id_valid        = ($urandom_range(0, 3) != 0);
    id_regwrite     = ($urandom_range(0, 3) != 0);
    id_is_load      = ($urandom_range(0, 2) == 0);
    id_rd           = 5'($urandom_range(0, 7));
    id_rs1          = 5'($urandom_range(0, 7));
    id_rs2          = 5'($urandom_range(0, 7));
    id_use_rs1      = ($urandom_range(0, 3) != 0);
    id_use_rs2      = ($urandom_range(0, 1) != 0);
    ext_stall       = ($urandom_range(0, 7) == 0);
    redirect_req    = ($urandom_range(0, 7) == 0);
    redirect_target = $urandom;
  endtask

  initial begin
    checks = 0; errors = 0;
    model_clear();
    rst = 1'b1;
    issue(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    #1;
    rst = 1'b0;
    // Reset held with random inputs: every output quiet
    for (int c = 0; c < 3; c++) begin
      rand_inputs();
      #1;
      check_value("rst_stall_if", 32'(o_stall_if[0]), 32'h0);
      step();
    end
    rst = 1'b1;
    // No producers in flight
    for (int c = 0; c < 5; c++) begin
      issue(1'b1, 1'b0, 1'b0, c + 1, c + 2, 1'b1, c + 3, 1'b1);
      step();
      check_value("idle_fwd_a", 32'(o_fa[0]), 32'h0);
    end
    // ALU forward distance 0, 1 and 2
    issue(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b1, 1'b0, 6, 5, 1'b1, 1, 1'b1); step();
    check_value("alu_fwd1", 32'(o_fa[0]), 32'd1);
    drain();
    issue(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b1, 1'b0, 9, 2, 1'b1, 3, 1'b1); step();
    issue(1'b1, 1'b1, 1'b0, 6, 5, 1'b1, 1, 1'b1); step();
    check_value("alu_fwd2", 32'(o_fa[0]), 32'd2);
    drain();
    issue(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b1, 1'b0, 9, 2, 1'b1, 3, 1'b1); step();
    issue(1'b1, 1'b1, 1'b0, 10, 2, 1'b1, 3, 1'b1); step();
    issue(1'b1, 1'b1, 1'b0, 6, 5, 1'b1, 1, 1'b1);
    #1;
    check_value("wb_bypass", 32'(o_byp_a[0]), 32'd1);
    step();
    drain();
    // Load-use: one stall cycle, then forward from MEM/WB
    issue(1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b1, 1'b0, 8, 7, 1'b1, 7, 1'b1);
    #1;
    check_value("lu_stall", 32'(o_stall_if[0]), 32'd1);
    check_value("lu_bubble", 32'(o_bubble[0]), 32'd1);
    step();
    #1;
    check_value("lu_release", 32'(o_stall_if[0]), 32'd0);
    step();
    check_value("lu_fwd_a", 32'(o_fa[0]), 32'd2);
    check_value("lu_fwd_b", 32'(o_fb[0]), 32'd2);
    check_value("lu_cnt", 32'(sc0), 32'd1);
    drain();
    // Youngest producer wins; x0 never matches
    issue(1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b1, 1'b0, 3, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b0, 1'b0, 0, 3, 1'b1, 0, 1'b0); step();
    check_value("youngest", 32'(o_fa[0]), 32'd1);
    drain();
    issue(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b1);
    #1;
    check_value("x0_stall", 32'(o_stall_if[0]), 32'd0);
    step();
    check_value("x0_fwd", 32'(o_fa[0]), 32'd0);
    drain();
    // Redirect beats a load-use stall
    issue(1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b1, 1'b0, 8, 7, 1'b1, 7, 1'b1);
    redirect_req = 1'b1; redirect_target = 32'h0000_0040;
    #1;
    check_value("rd_stall_if", 32'(o_stall_if[0]), 32'd0);
    check_value("rd_flush", 32'(o_flush[0]), 32'd1);
    check_value("rd_pc", o_pc[0], 32'h0000_0040);
    check_value("rd_kill_br1", 32'(o_kill[1]), 32'd1);
    step();
    check_value("rd_flush_cnt", 32'(fc0), 32'd1);
    check_value("rd_stall_cnt", 32'(sc0), 32'd1);
    drain();
    // ext_stall freezes a pending hazard; stall happens once afterwards
    issue(1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 0, 1'b0); step();
    issue(1'b1, 1'b0, 1'b0, 0, 7, 1'b1, 7, 1'b1);
    ext_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_value("ext_stall_if", 32'(o_stall_if[0]), 32'd1);
      check_value("ext_bubble", 32'(o_bubble[0]), 32'd0);
      step();
    end
    ext_stall = 1'b0;
    #1;
    check_value("ext_resume_stall", 32'(o_stall_if[0]), 32'd1);
    step();
    #1;
    check_value("ext_resume_go", 32'(o_stall_if[0]), 32'd0);
    step();
    check_value("ext_fwd", 32'(o_fa[0]), 32'd2);
    check_value("ext_cnt", 32'(sc0), 32'd2);
    drain();
    // Five more load-use stalls: 2-bit counter saturates
    for (int n = 0; n < 5; n++) begin
      issue(1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 0, 1'b0); step();
      issue(1'b1, 1'b0, 1'b0, 0, 7, 1'b1, 0, 1'b0); step();
      step();
      drain();
    end
    check_value("sat_cnt2", 32'(sc1), 32'd3);
    check_value("sat_cnt16", 32'(sc0), 32'd7);
    // Randomized traffic including mid-run resets
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      rst = ($urandom_range(0, 79) != 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
